// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
//   REG_ADDR / REG_SIZE / REG_N : register file geometry
//   WB_NREQ                     : default number of writeback requesters
//   WB_ALU / WB_MEM / WB_MUL    : requester slot assignment on the arbiter
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR = 5;
  localparam int REG_SIZE = 32;
  localparam int REG_N    = 32;

  localparam int WB_NREQ  = 3;
  localparam int WB_ALU   = 0;
  localparam int WB_MEM   = 1;
  localparam int WB_MUL   = 2;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index; search runs upward from here and wraps
//   gnt     : one-hot grant, zero when no request is present
//   gnt_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // NOTE: every variable written in this block gets a default at the top, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate index (ptr + k) mod N; one extra bit avoids overflow.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port among NREQ writeback requesters.
// Requesters are granted round-robin; the winner is registered into a
// one-entry output stage that drives the register file. The in-flight write
// is forwarded to the two decode read ports.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb_hold               : blocks new grants; the output stage still drains
//   req_valid/wreg/wdata  : per-requester write requests (packed slices)
//   req_ready             : one-hot grant (zero under hold, reset, or idle)
//   regwrite/wreg/wdata   : register-file write port
//   rreg1/rreg2           : decode read addresses
//   fwd_hit*/fwd_data*    : forwarding of the in-flight write
//   conflict_cnt          : saturating count of cycles with >=2 requesters
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ        = WB_NREQ,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*REG_ADDR-1:0] req_wreg,
  input  logic [NREQ*REG_SIZE-1:0] req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     regwrite,
  output logic [REG_ADDR-1:0]      wreg,
  output logic [REG_SIZE-1:0]      wdata,
  input  logic [REG_ADDR-1:0]      rreg1,
  input  logic [REG_ADDR-1:0]      rreg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [REG_SIZE-1:0]      fwd_data1,
  output logic [REG_SIZE-1:0]      fwd_data2,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [NREQ-1:0]     gnt;
  logic                transfer;
  logic                multi_valid;
  logic [REG_ADDR-1:0] sel_wreg;
  logic [REG_SIZE-1:0] sel_wdata;

  rr_arbiter #(.N(NREQ), .IW(PTR_W)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is suppressed while held and while reset is asserted.
  assign req_ready = (wb_hold || !rst_n) ? '0 : gnt;
  assign transfer  = |req_ready;

  // Clearing the lowest set bit leaves a nonzero value only when >=2 are set.
  assign multi_valid = (req_valid & (req_valid - NREQ'(1))) != '0;

  always_comb begin
    sel_wreg  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_wreg  = req_wreg[i*REG_ADDR +: REG_ADDR];
        sel_wdata = req_wdata[i*REG_SIZE +: REG_SIZE];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
      rr_ptr   <= '0;
    end else begin
      // Writes to register 0 are consumed but never issued.
      regwrite <= transfer && !(ZERO_REG_EN && (sel_wreg == '0));
      if (transfer) begin
        wreg   <= sel_wreg;
        wdata  <= sel_wdata;
        rr_ptr <= (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (multi_valid && !wb_hold && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign fwd_hit1  = regwrite && (wreg == rreg1);
  assign fwd_hit2  = regwrite && (wreg == rreg2);
  assign fwd_data1 = wdata;
  assign fwd_data2 = wdata;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. A second instance with a 2-bit
// counter and register-0 writes enabled runs on the same stimulus so that
// saturation and the ZERO_REG_EN=0 path are reachable in a few cycles.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   wb_hold;
  logic [N-1:0]           req_valid;
  logic [N*REG_ADDR-1:0]  req_wreg;
  logic [N*REG_SIZE-1:0]  req_wdata;
  logic [REG_ADDR-1:0]    rreg1, rreg2;

  logic [N-1:0]           req_ready, b_req_ready;
  logic                   regwrite, b_regwrite;
  logic [REG_ADDR-1:0]    wreg, b_wreg;
  logic [REG_SIZE-1:0]    wdata, b_wdata;
  logic                   fwd_hit1, fwd_hit2, b_fwd_hit1, b_fwd_hit2;
  logic [REG_SIZE-1:0]    fwd_data1, fwd_data2, b_fwd_data1, b_fwd_data2;
  logic [15:0]            conflict_cnt;
  logic [1:0]             b_conflict_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(N), .ZERO_REG_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_hold(wb_hold),
    .req_valid(req_valid), .req_wreg(req_wreg), .req_wdata(req_wdata),
    .req_ready(req_ready), .regwrite(regwrite), .wreg(wreg), .wdata(wdata),
    .rreg1(rreg1), .rreg2(rreg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.NREQ(N), .ZERO_REG_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .wb_hold(wb_hold),
    .req_valid(req_valid), .req_wreg(req_wreg), .req_wdata(req_wdata),
    .req_ready(b_req_ready), .regwrite(b_regwrite), .wreg(b_wreg), .wdata(b_wdata),
    .rreg1(rreg1), .rreg2(rreg2),
    .fwd_hit1(b_fwd_hit1), .fwd_hit2(b_fwd_hit2),
    .fwd_data1(b_fwd_data1), .fwd_data2(b_fwd_data2),
    .conflict_cnt(b_conflict_cnt)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [REG_ADDR-1:0] r,
                         input logic [REG_SIZE-1:0] d);
    req_wreg[i*REG_ADDR +: REG_ADDR]  = r;
    req_wdata[i*REG_SIZE +: REG_SIZE] = d;
  endtask

  // Mid-cycle reset pulse; returns at edge+1 with rr_ptr=0.
  task automatic do_reset();
    req_valid = '0;
    wb_hold   = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (regwrite !== 1'b0 || wreg !== '0 || wdata !== '0) begin failures++; $display("FAIL reset_outstage got=%b/%0d/%h exp=0/0/0", regwrite, wreg, wdata); end
    checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
    req_valid = '0;
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(WB_ALU, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (regwrite !== 1'b1 || wreg !== 5'd5 || wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", regwrite, wreg, wdata); end
    tick();
    checks++; if (regwrite !== 1'b0 || wreg !== 5'd5) begin failures++; $display("FAIL single_drain got=%b/%0d exp=0/5", regwrite, wreg); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, REG_ADDR'(10 + i), 32'hA000_0000 + i);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_gnt = N'(1) << (c % N);
      #1;
      checks++; if (req_ready !== exp_gnt) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_gnt); end
      tick();
      checks++; if (regwrite !== 1'b1 || wreg !== REG_ADDR'(10 + c % N) || wdata !== 32'hA000_0000 + (c % N)) begin failures++; $display("FAIL rr_write c=%0d got=%b/%0d/%h", c, regwrite, wreg, wdata); end
    end
    req_valid = '0;
    checks++; if (conflict_cnt !== 16'd6) begin failures++; $display("FAIL rr_conflict got=%0d exp=6", conflict_cnt); end
    checks++; if (b_conflict_cnt !== 2'd3) begin failures++; $display("FAIL rr_conflict_sat got=%0d exp=3", b_conflict_cnt); end
    tick();
  endtask

  task automatic test_zero_reg();
    // rr_ptr is 0 here: requester 0 (address 0) wins first.
    set_req(WB_ALU, 5'd0, 32'h1111_1111);
    set_req(WB_MUL, 5'd9, 32'h2222_2222);
    req_valid = 3'b101;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL zero_grant0 got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b100;
    #1;
    checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL zero_suppress got=%b exp=0", regwrite); end
    checks++; if (b_regwrite !== 1'b1 || b_wreg !== 5'd0) begin failures++; $display("FAIL zero_disabled got=%b/%0d exp=1/0", b_regwrite, b_wreg); end
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL zero_grant2 got=%b exp=100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (regwrite !== 1'b1 || wreg !== 5'd9 || wdata !== 32'h2222_2222) begin failures++; $display("FAIL zero_next got=%b/%0d/%h exp=1/9/22222222", regwrite, wreg, wdata); end
    tick();
  endtask

  task automatic test_forward();
    set_req(WB_ALU, 5'd7, 32'h1234_5678);
    rreg1 = 5'd7;
    rreg2 = 5'd8;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    #1;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h1234_5678) begin failures++; $display("FAIL fwd_hit1 got=%b/%h exp=1/12345678", fwd_hit1, fwd_data1); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h1234_5678) begin failures++; $display("FAIL fwd_hit2 got=%b/%h exp=0/12345678", fwd_hit2, fwd_data2); end
    tick();
    checks++; if (fwd_hit1 !== 1'b0) begin failures++; $display("FAIL fwd_idle got=%b exp=0", fwd_hit1); end
  endtask

  task automatic test_hold();
    // rr_ptr is 1 after the requester-0 write above.
    set_req(WB_MEM, 5'd3, 32'h0000_0333);
    req_valid = 3'b010;
    tick();
    wb_hold   = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++; if (regwrite !== 1'b1 || wreg !== 5'd3) begin failures++; $display("FAIL hold_drain got=%b/%0d exp=1/3", regwrite, wreg); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL hold_ready c=%0d got=%b exp=000", c, req_ready); end
      tick();
    end
    checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL hold_no_write got=%b exp=0", regwrite); end
    checks++; if (conflict_cnt !== 16'd7) begin failures++; $display("FAIL hold_cnt got=%0d exp=7", conflict_cnt); end
    // Frozen pointer is 2.
    wb_hold = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL hold_resume0 got=%b exp=100", req_ready); end
    tick();
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL hold_resume1 got=%b exp=001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_async_reset_and_sat();
    set_req(WB_MEM, 5'd4, 32'h0000_0444);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    checks++; if (regwrite !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", regwrite); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (regwrite !== 1'b0 || wreg !== '0 || wdata !== '0 || conflict_cnt !== '0) begin failures++; $display("FAIL areset_now got=%b/%0d/%h/%0d exp=0/0/0/0", regwrite, wreg, wdata, conflict_cnt); end
    #2 rst_n = 1'b1;
    tick();
    // Narrow counter: two conflict cycles reach all-ones minus one.
    req_valid = 3'b011;
    tick();
    tick();
    checks++; if (b_conflict_cnt !== 2'd2) begin failures++; $display("FAIL sat_pre got=%0d exp=2", b_conflict_cnt); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (b_conflict_cnt !== 2'd3) begin failures++; $display("FAIL sat_hold c=%0d got=%0d exp=3", c, b_conflict_cnt); end
    end
    checks++; if (conflict_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide got=%0d exp=5", conflict_cnt); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    wb_hold   = 1'b0;
    req_valid = '0;
    req_wreg  = '0;
    req_wdata = '0;
    rreg1     = '0;
    rreg2     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_reg();
    test_forward();
    test_hold();
    test_async_reset_and_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
